// File: rtl/usb_tx_sched.sv
// usb_tx_sched: transmit scheduler in front of usb_tx.
//
// It arbitrates between the handshake source (ACK/NAK) and the endpoint data
// buffer (DATA). It presents the granted packet to usb_tx and forwards usb_tx
// byte fetches to the buffer as pop strobes. After every packet it enforces an
// inter-packet gap. A watchdog abandons a packet that usb_tx never completes.
//
// Ports:
//   clk, n_rst                 clock, synchronous active-low reset
//   hs_req, hs_nak, hs_done    handshake requester (level req, done pulse)
//   data_req, data_size        data requester (level req, size 0..64)
//   data_in, data_pop          head byte of data buffer / advance strobe
//   data_done                  data packet completed or timed out (pulse)
//   tx_packet[1:0]             to usb_tx: 00 IDLE, 01 DATA, 10 ACK, 11 NAK
//   tx_packet_data_size[6:0]   to usb_tx: payload byte count
//   tx_packet_data[7:0]        to usb_tx: current payload byte (pass-through)
//   get_tx_packet, tx_done     from usb_tx: byte fetch strobe, packet complete
//   busy                       scheduler not in IDLE
//   timeout_err                watchdog expiry pulse
module usb_tx_sched #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic       hs_nak,
  output logic       hs_done,
  input  logic       data_req,
  input  logic [6:0] data_size,
  input  logic [7:0] data_in,
  output logic       data_pop,
  output logic       data_done,
  output logic [1:0] tx_packet,
  output logic [6:0] tx_packet_data_size,
  output logic [7:0] tx_packet_data,
  input  logic       get_tx_packet,
  input  logic       tx_done,
  output logic       busy,
  output logic       timeout_err
);

  // Counter widths are kept at least 1 bit so the degenerate parameter
  // values (no gap, 1-cycle timeout) still elaborate.
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] WD_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [1:0] PKT_IDLE = 2'b00;
  localparam logic [1:0] PKT_DATA = 2'b01;
  localparam logic [1:0] PKT_ACK  = 2'b10;
  localparam logic [1:0] PKT_NAK  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_hs_q, owner_hs_d;
  logic          last_hs_q, last_hs_d;
  logic [TW-1:0] wdog_q, wdog_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    pkt_q, pkt_d;
  logic [6:0]    size_q, size_d;
  logic          hs_done_q, hs_done_d;
  logic          data_done_q, data_done_d;
  logic          timeout_q, timeout_d;
  logic          grant_hs;

  // Handshake has priority unless it was served last and data is waiting.
  assign grant_hs = hs_req && !(data_req && last_hs_q);

  always_comb begin
    state_d     = state_q;
    owner_hs_d  = owner_hs_q;
    last_hs_d   = last_hs_q;
    wdog_d      = wdog_q;
    gap_d       = gap_q;
    pkt_d       = pkt_q;
    size_d      = size_q;
    hs_done_d   = 1'b0;
    data_done_d = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_hs) begin
          state_d    = ST_SEND;
          owner_hs_d = 1'b1;
          pkt_d      = hs_nak ? PKT_NAK : PKT_ACK;
          size_d     = 7'd0;
          wdog_d     = '0;
        end else if (data_req) begin
          state_d    = ST_SEND;
          owner_hs_d = 1'b0;
          pkt_d      = PKT_DATA;
          size_d     = data_size;
          wdog_d     = '0;
        end
      end

      ST_SEND: begin
        // Completion and watchdog expiry share one exit; a coincident
        // tx_done counts as a normal completion.
        if (tx_done || (wdog_q == WD_LAST)) begin
          hs_done_d   = owner_hs_q;
          data_done_d = !owner_hs_q;
          timeout_d   = !tx_done;
          pkt_d       = PKT_IDLE;
          size_d      = 7'd0;
          last_hs_d   = owner_hs_q;
          gap_d       = '0;
          state_d     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + TW'(1);
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else if (gap_q != '1) begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      owner_hs_q  <= 1'b0;
      last_hs_q   <= 1'b0;
      wdog_q      <= '0;
      gap_q       <= '0;
      pkt_q       <= PKT_IDLE;
      size_q      <= 7'd0;
      hs_done_q   <= 1'b0;
      data_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_hs_q  <= owner_hs_d;
      last_hs_q   <= last_hs_d;
      wdog_q      <= wdog_d;
      gap_q       <= gap_d;
      pkt_q       <= pkt_d;
      size_q      <= size_d;
      hs_done_q   <= hs_done_d;
      data_done_q <= data_done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign tx_packet           = pkt_q;
  assign tx_packet_data_size = size_q;
  assign tx_packet_data      = data_in;
  assign hs_done             = hs_done_q;
  assign data_done           = data_done_q;
  assign timeout_err         = timeout_q;
  assign busy                = (state_q != ST_IDLE);
  // Fetches during a handshake must not drain the data buffer.
  assign data_pop            = get_tx_packet && (state_q == ST_SEND) && !owner_hs_q;

endmodule

// File: tb/tb_usb_tx_sched.sv
module tb_usb_tx_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst, hs_req, hs_nak, data_req, get_tx_packet, tx_done;
  logic [6:0] data_size;
  logic [7:0] data_in;

  logic       hs_done_w[2], data_pop_w[2], data_done_w[2], busy_w[2], to_w[2];
  logic [1:0] pkt_w[2];
  logic [6:0] sz_w[2];
  logic [7:0] pd_w[2];

  // Instance 0: 16-cycle gap, 32-cycle watchdog. Instance 1: no gap.
  usb_tx_sched #(.GAP_CYCLES(16), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .n_rst(n_rst), .hs_req(hs_req), .hs_nak(hs_nak),
    .hs_done(hs_done_w[0]), .data_req(data_req), .data_size(data_size),
    .data_in(data_in), .data_pop(data_pop_w[0]), .data_done(data_done_w[0]),
    .tx_packet(pkt_w[0]), .tx_packet_data_size(sz_w[0]),
    .tx_packet_data(pd_w[0]), .get_tx_packet(get_tx_packet),
    .tx_done(tx_done), .busy(busy_w[0]), .timeout_err(to_w[0]));

  usb_tx_sched #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(32)) dut_nogap (
    .clk(clk), .n_rst(n_rst), .hs_req(hs_req), .hs_nak(hs_nak),
    .hs_done(hs_done_w[1]), .data_req(data_req), .data_size(data_size),
    .data_in(data_in), .data_pop(data_pop_w[1]), .data_done(data_done_w[1]),
    .tx_packet(pkt_w[1]), .tx_packet_data_size(sz_w[1]),
    .tx_packet_data(pd_w[1]), .get_tx_packet(get_tx_packet),
    .tx_done(tx_done), .busy(busy_w[1]), .timeout_err(to_w[1]));

  typedef struct {
    int         rep;
    logic       rst, hreq, nak, dreq;
    logic [6:0] dsz;
    logic [7:0] din;
    logic       get, done;
    logic [1:0] pkt;
    logic [6:0] sz;
    logic       hsd, dd, busy, to, pop;
  } vec_t;

  typedef struct {
    logic [1:0] pkt;
    logic [6:0] sz;
    logic       hsd, dd, busy, to;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cur   = 0;

  function automatic vec_t mk(int rep, int rst, int hreq, int nak, int dreq,
                              int dsz, int din, int get, int done, int pkt,
                              int sz, int hsd, int dd, int busy, int to, int pop);
    vec_t v;
    v.rep  = rep;
    v.rst  = 1'(rst);  v.hreq = 1'(hreq); v.nak = 1'(nak);  v.dreq = 1'(dreq);
    v.dsz  = 7'(dsz);  v.din  = 8'(din);  v.get = 1'(get);  v.done = 1'(done);
    v.pkt  = 2'(pkt);  v.sz   = 7'(sz);   v.hsd = 1'(hsd);  v.dd   = 1'(dd);
    v.busy = 1'(busy); v.to   = 1'(to);   v.pop = 1'(pop);
    return v;
  endfunction

  function automatic void add(int rep, int rst, int hreq, int nak, int dreq,
                              int dsz, int din, int get, int done, int pkt,
                              int sz, int hsd, int dd, int busy, int to, int pop);
    tbl.push_back(mk(rep, rst, hreq, nak, dreq, dsz, din, get, done,
                     pkt, sz, hsd, dd, busy, to, pop));
  endfunction

  function automatic void chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", nm, cur, act, req);
    end
  endfunction

  // One clock: drive at negedge, check combinational outputs, queue the
  // expected registered outputs, then compare them just after the posedge.
  task automatic step(input vec_t v, input int sel);
    exp_t e;
    @(negedge clk);
    n_rst = v.rst; hs_req = v.hreq; hs_nak = v.nak; data_req = v.dreq;
    data_size = v.dsz; data_in = v.din; get_tx_packet = v.get; tx_done = v.done;
    #1;
    if (v.rst) begin
      chk("data_pop", int'(data_pop_w[sel]), int'(v.pop));
      chk("tx_packet_data", int'(pd_w[sel]), int'(v.din));
    end
    e.pkt = v.pkt; e.sz = v.sz; e.hsd = v.hsd; e.dd = v.dd;
    e.busy = v.busy; e.to = v.to;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("tx_packet", int'(pkt_w[sel]), int'(e.pkt));
    chk("tx_packet_data_size", int'(sz_w[sel]), int'(e.sz));
    chk("hs_done", int'(hs_done_w[sel]), int'(e.hsd));
    chk("data_done", int'(data_done_w[sel]), int'(e.dd));
    chk("busy", int'(busy_w[sel]), int'(e.busy));
    chk("timeout_err", int'(to_w[sel]), int'(e.to));
  endtask

  initial begin
    n_rst = 1'b0; hs_req = 1'b0; hs_nak = 1'b0; data_req = 1'b0;
    data_size = 7'd0; data_in = 8'd0; get_tx_packet = 1'b0; tx_done = 1'b0;

    // rep rst hreq nak dreq dsz din get done | pkt sz hsd dd busy to pop
    // Single NAK handshake, gap, stray inputs in GAP and IDLE.
    add(1, 0,0,0,0, 0,'h00, 0,0,  0,0, 0,0,0,0, 0);
    add(1, 1,1,1,0, 0,'h11, 0,0,  3,0, 0,0,1,0, 0);
    add(1, 1,1,0,0, 0,'h12, 1,0,  3,0, 0,0,1,0, 0);
    add(1, 1,1,0,0, 0,'h13, 0,1,  0,0, 1,0,1,0, 0);
    add(15,1,0,0,0, 0,'h14, 1,1,  0,0, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h15, 1,1,  0,0, 0,0,0,0, 0);
    add(2, 1,0,0,0, 0,'h16, 1,1,  0,0, 0,0,0,0, 0);
    // Data streaming, 5 bytes; req dropped after grant, size change ignored.
    add(1, 1,0,0,1, 5,'h9F, 0,0,  1,5, 0,0,1,0, 0);
    add(1, 1,0,0,0, 9,'hA0, 1,0,  1,5, 0,0,1,0, 1);
    add(1, 1,0,0,0, 9,'hA1, 1,0,  1,5, 0,0,1,0, 1);
    add(1, 1,0,0,0, 9,'h77, 0,0,  1,5, 0,0,1,0, 0);
    add(1, 1,0,0,0, 9,'hA2, 1,0,  1,5, 0,0,1,0, 1);
    add(1, 1,0,0,0, 9,'hA3, 1,0,  1,5, 0,0,1,0, 1);
    add(1, 1,0,0,0, 9,'hA4, 1,0,  1,5, 0,0,1,0, 1);
    add(1, 1,0,0,0, 0,'hA5, 0,1,  0,0, 0,1,1,0, 0);
    add(15,1,0,0,0, 0,'h00, 0,0,  0,0, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h00, 0,0,  0,0, 0,0,0,0, 0);
    // Contention: ACK first, then DATA, then NAK; no grant during GAP.
    add(1, 1,1,0,1, 3,'h00, 0,0,  2,0, 0,0,1,0, 0);
    add(1, 1,1,0,1, 3,'h00, 1,1,  0,0, 1,0,1,0, 0);
    add(15,1,1,0,1, 3,'h00, 0,0,  0,0, 0,0,1,0, 0);
    add(1, 1,1,0,1, 3,'h00, 0,0,  0,0, 0,0,0,0, 0);
    add(1, 1,1,0,1, 3,'h00, 0,0,  1,3, 0,0,1,0, 0);
    add(1, 1,1,1,1, 3,'h00, 0,1,  0,0, 0,1,1,0, 0);
    add(15,1,1,1,1, 3,'h00, 0,0,  0,0, 0,0,1,0, 0);
    add(1, 1,1,1,1, 3,'h00, 0,0,  0,0, 0,0,0,0, 0);
    add(1, 1,1,1,1, 3,'h00, 0,0,  3,0, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h00, 0,1,  0,0, 1,0,1,0, 0);
    add(15,1,0,0,0, 0,'h00, 0,0,  0,0, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h00, 0,0,  0,0, 0,0,0,0, 0);
    // Watchdog expiry after 32 SEND cycles.
    add(1, 1,0,0,1, 7,'h00, 0,0,  1,7, 0,0,1,0, 0);
    add(31,1,0,0,0, 0,'h00, 0,0,  1,7, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h00, 0,0,  0,0, 0,1,1,1, 0);
    add(15,1,0,0,0, 0,'h00, 0,0,  0,0, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h00, 0,0,  0,0, 0,0,0,0, 0);
    // tx_done on the expiry cycle: completion, no error.
    add(1, 1,0,0,1, 2,'h00, 0,0,  1,2, 0,0,1,0, 0);
    add(31,1,0,0,0, 0,'h00, 0,0,  1,2, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h00, 0,1,  0,0, 0,1,1,0, 0);
    add(15,1,0,0,0, 0,'h00, 0,0,  0,0, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h00, 0,0,  0,0, 0,0,0,0, 0);
    // Reset mid-DATA, pending hs_req granted right after release.
    add(1, 1,0,0,1, 4,'h00, 0,0,  1,4, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h55, 1,0,  1,4, 0,0,1,0, 1);
    add(1, 0,1,0,0, 0,'h56, 1,0,  0,0, 0,0,0,0, 0);
    add(1, 1,1,0,0, 0,'h00, 0,0,  2,0, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h00, 0,1,  0,0, 1,0,1,0, 0);
    add(15,1,0,0,0, 0,'h00, 0,0,  0,0, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h00, 0,0,  0,0, 0,0,0,0, 0);
    // Zero-length DATA packet.
    add(1, 1,0,0,1, 0,'h00, 0,0,  1,0, 0,0,1,0, 0);
    add(1, 1,0,0,0, 0,'h00, 0,1,  0,0, 0,1,1,0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cur = i;
      for (int r = 0; r < tbl[i].rep; r++) step(tbl[i], 0);
    end

    // No-gap instance: completion returns straight to IDLE and the next
    // request is granted on the following edge.
    cur = 1000;
    step(mk(1, 0,0,0,0, 0,'h00, 0,0,  0,0, 0,0,0,0, 0), 1);
    step(mk(1, 1,1,0,0, 0,'h00, 0,0,  2,0, 0,0,1,0, 0), 1);
    step(mk(1, 1,1,0,0, 0,'h00, 0,1,  0,0, 1,0,0,0, 0), 1);
    step(mk(1, 1,1,1,0, 0,'h00, 0,0,  3,0, 0,0,1,0, 0), 1);
    step(mk(1, 1,0,0,1, 6,'h00, 0,1,  0,0, 1,0,0,0, 0), 1);
    step(mk(1, 1,0,0,1, 6,'h3C, 0,0,  1,6, 0,0,1,0, 0), 1);
    step(mk(1, 1,0,0,0, 0,'h3D, 1,1,  0,0, 0,1,0,0, 1), 1);
    step(mk(1, 1,0,0,0, 0,'h3E, 1,1,  0,0, 0,0,0,0, 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
